// File: rtl/piso_pkg.sv
// Shared types and default sizing for the arbitrated parallel-in/serial-out block.
package piso_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_e;

endpackage

// File: rtl/piso_arb_ctrl_if.sv
// Requester-side handshake and serial output bundle.
interface piso_arb_ctrl_if
    import piso_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  sout;
    logic                  sout_valid;
    logic                  sof;
    logic [IW-1:0]         grant_id;
    logic                  busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, sout, sout_valid, sof, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, sout, sout_valid, sof, grant_id, busy
    );

endinterface

// File: rtl/piso_shift.sv
// Loadable left-shift register with zero fill; exposes its MSB.
module piso_shift
    import piso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

    assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/piso_arb_ctrl.sv
// Round-robin arbiter feeding a shared serialiser, MSB first.
// Define PISO_ARB_PARITY_EN to append an even-parity bit to each frame.
module piso_arb_ctrl
    import piso_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    piso_arb_ctrl_if.slave    bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
`ifdef PISO_ARB_PARITY_EN
    localparam logic [1:0] S_PAR   = ST_PAR;
`endif

    logic [1:0]       state;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    grant_q;
    logic [IW-1:0]    pick;
    logic             any;
    logic [CW-1:0]    cnt;
    logic             hs;
    logic             in_shift;
    logic             msb;
    logic [WIDTH-1:0] word;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        pick = last_grant;
        any  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && bus.req_valid[(int'(last_grant) + k) % NREQ]) begin
                any  = 1'b1;
                pick = IW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

    assign hs       = (state == S_IDLE) && any;
    assign word     = bus.req_data[pick*WIDTH +: WIDTH];
    assign in_shift = (state == S_SHIFT);

    assign bus.req_ready = hs ? (NREQ'(1) << pick) : '0;

`ifdef PISO_ARB_PARITY_EN
    logic par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else if (hs) begin
            par <= ^word;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_grant <= IW'(NREQ - 1);
            grant_q    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (hs) begin
                        state      <= S_SHIFT;
                        cnt        <= CW'(WIDTH - 1);
                        last_grant <= pick;
                        grant_q    <= pick;
                    end
                end
                S_SHIFT: begin
                    if (cnt == '0) begin
`ifdef PISO_ARB_PARITY_EN
                        state <= S_PAR;
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef PISO_ARB_PARITY_EN
                S_PAR: state <= S_IDLE;
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    piso_shift #(.WIDTH(WIDTH)) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hs),
        .shift (in_shift),
        .din   (word),
        .msb   (msb)
    );

`ifdef PISO_ARB_PARITY_EN
    assign bus.sout       = in_shift ? msb : ((state == S_PAR) && par);
    assign bus.sout_valid = in_shift || (state == S_PAR);
`else
    assign bus.sout       = in_shift && msb;
    assign bus.sout_valid = in_shift;
`endif
    assign bus.sof      = in_shift && (cnt == CW'(WIDTH - 1));
    assign bus.grant_id = grant_q;
    assign bus.busy     = (state != S_IDLE);

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Randomised bench for piso_arb_ctrl against a frame-queue reference model.
module tb_piso_arb_ctrl;
    import piso_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
`ifdef PISO_ARB_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_arb_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

    piso_arb_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: remaining frame bits, position in frame, arbitration history.
    bit mq[$];
    int fpos = 0;
    int m_last = NREQ - 1;
    int m_grant = 0;
    int cyc = 0;
    int gq[$];
    int tq[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] word_of(input int i);
        return bus.req_data[i*WIDTH +: WIDTH];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            fpos    = 0;
            m_last  = NREQ - 1;
            m_grant = 0;
        end else begin
            int p;
            logic [WIDTH-1:0] w;
            cyc++;
            if (mq.size() > 0) begin
                void'(mq.pop_front());
                fpos++;
            end else begin
                p = rr(bus.req_valid);
                if (p >= 0) begin
                    w = word_of(p);
                    for (int i = WIDTH - 1; i >= 0; i--) mq.push_back(w[i]);
`ifdef PISO_ARB_PARITY_EN
                    mq.push_back(^w);
`endif
                    m_last  = p;
                    m_grant = p;
                    fpos    = 0;
                    gq.push_back(p);
                    tq.push_back(cyc);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                logic [NREQ-1:0] er;
                int p;
                er = '0;
                if (mq.size() > 0) begin
                    check("sout", bus.sout, mq[0]);
                    check("sout_valid", bus.sout_valid, 1);
                    check("sof", bus.sof, fpos == 0);
                    check("busy", bus.busy, 1);
                end else begin
                    check("sout_idle", bus.sout, 0);
                    check("sout_valid_idle", bus.sout_valid, 0);
                    check("sof_idle", bus.sof, 0);
                    check("busy_idle", bus.busy, 0);
                    p = rr(bus.req_valid);
                    if (p >= 0) er = NREQ'(1) << p;
                end
                check("req_ready", bus.req_ready, er);
                check("grant_id", bus.grant_id, m_grant);
            end
        end
    end

    initial begin
        logic [3:0] lit;
        int s;
        int r3;
        int n3;
        bit found;

        bus.req_valid = '0;
        bus.req_data  = '0;

        #12;
        check("rst_sout", bus.sout, 0);
        check("rst_sout_valid", bus.sout_valid, 0);
        check("rst_sof", bus.sof, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_grant", bus.grant_id, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Single request, word 1011.
        @(posedge clk);
        #1;
        bus.req_data  = 16'h000B;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("t1_ready", bus.req_ready, 4'b0001);
        @(posedge clk);
        #1 bus.req_valid = '0;
        lit = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_sout", bus.sout, lit[3-i]);
            check("t1_sof", bus.sof, i == 0);
            check("t1_ready_busy", bus.req_ready, 0);
        end
`ifdef PISO_ARB_PARITY_EN
        @(negedge clk);
        check("t1_parity", bus.sout, 1);
        check("t1_parity_valid", bus.sout_valid, 1);
`endif
        @(negedge clk);
        check("t1_idle", bus.busy, 0);

        // Contention: all held; last winner was 0.
        @(posedge clk);
        #1;
        bus.req_data  = {$urandom, $urandom};
        bus.req_valid = 4'hF;
        s = gq.size();
        repeat (4 * (FLEN + 1) + 2) @(posedge clk);
        #1 bus.req_valid = '0;
        check("cont_count", gq.size() - s >= 5, 1);
        if (gq.size() - s >= 5) begin
            for (int k = 0; k < 5; k++) check("cont_order", gq[s+k], (k + 1) % 4);
            for (int k = 0; k < 4; k++) check("cont_spacing", tq[s+k+1] - tq[s+k], FLEN + 1);
        end
        repeat (FLEN + 2) @(posedge clk);

        // Random traffic, including late arrivals and withdrawals.
        repeat (600) begin
            @(posedge clk);
            #1;
            bus.req_data  = {$urandom, $urandom};
            bus.req_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
        end

        // Requester 3 pulses valid for one cycle while busy.
        @(posedge clk);
        #1 bus.req_valid = 4'b0001;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = (mq.size() >= 3);
        end
        check("wd_wait", found, 1);
        s = gq.size();
        r3 = 0;
        @(posedge clk);
        #1 bus.req_valid = 4'b1000;
        @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (2 * FLEN + 4) begin
            @(negedge clk);
            if (bus.req_ready[3]) r3++;
        end
        n3 = 0;
        for (int k = s; k < gq.size(); k++) if (gq[k] == 3) n3++;
        check("wd_ready3", r3, 0);
        check("wd_frame3", n3, 0);

        // Reset in the second shift cycle.
        @(posedge clk);
        #1 bus.req_valid = 4'b0001;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = (mq.size() > 0) && (fpos == 1);
        end
        check("rst_wait", found, 1);
        #2;
        rst_n = 1'b0;
        bus.req_valid = 4'b1010;
        #1;
        check("mid_sout", bus.sout, 0);
        check("mid_sout_valid", bus.sout_valid, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_sof", bus.sof, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("post_ready", bus.req_ready, 4'b0010);
        @(negedge clk);
        check("post_grant", bus.grant_id, 1);
        check("post_sof", bus.sof, 1);
        #1 bus.req_valid = '0;
        repeat (2 * FLEN + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/piso_arb_ctrl.md
PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the serialiser (2..8).
REQ-002 Parameter WIDTH, default 4, bits per parallel word.
REQ-003 One clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NREQ  per-requester word available.
REQ-007 req_data  input  NREQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  one-hot accept strobe; handshake completes on a cycle with valid and ready both high.
REQ-009 sout  output  1  serial data, MSB first.
REQ-010 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-011 sof  output  1  high with the first bit of each frame.
REQ-012 grant_id  output  clog2(NREQ)  requester owning the current frame.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, SHIFT, PAR (PAR exists only with the macro enabled, see REQ-026).
REQ-015 IDLE: if any req_valid, the block SHALL raise req_ready for exactly one requester, chosen round-robin, combinationally in the same cycle.
REQ-016 Round-robin: search starts at (last_grant+1) mod NREQ; last_grant updates only on a completed handshake.
REQ-017 On the handshake edge: shift register loads the granted word, grant_id latches, bit counter loads WIDTH-1, state -> SHIFT.
REQ-018 SHIFT: sout = shift register MSB, sout_valid=1; each edge shifts left with zero fill and decrements the counter; sof=1 only in the first SHIFT cycle.
REQ-019 Latency: first bit appears in the cycle after the handshake; the frame lasts exactly WIDTH cycles (WIDTH+1 with parity).
REQ-020 At counter 0 the state goes to PAR (macro on) or IDLE (macro off); IDLE always lasts at least one cycle, so consecutive frames are separated by one idle cycle.
REQ-021 req_ready SHALL be 0 in every state other than IDLE; requests arriving during a frame wait.
REQ-022 A requester that drops req_valid before it is granted loses nothing; no state changes.
REQ-023 Outside a frame: sout=0, sout_valid=0, sof=0; grant_id holds its last value.

Reset
REQ-024 Reset values: state IDLE, shift register 0, counter 0, last_grant NREQ-1 (so requester 0 wins first), grant_id 0, all outputs 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with no completion bit; after reset release the first grant follows REQ-024.

Configuration
REQ-026 Macro PISO_ARB_PARITY_EN: when defined, the PAR state emits one extra bit, the even parity (XOR) of the loaded word, with sout_valid=1 and sof=0.
REQ-027 Without PISO_ARB_PARITY_EN, PAR logic is absent and frames are exactly WIDTH bits.

Structure
REQ-028 Package piso_pkg holds the state enum typedef and the default WIDTH/NREQ constants.
REQ-029 Sub-module piso_shift holds the load/shift register and MSB output; piso_arb_ctrl holds the arbiter, FSM and counter.

Verification
REQ-030 Single request: req_valid[0]=1, data0=4'b1011 -> ready[0] for 1 cycle; next 4 cycles sout 1,0,1,1 with sof on the first; then IDLE.
REQ-031 Contention: all 4 valid and held -> grants in order 0,1,2,3,0 with 5-cycle spacing (macro off) and grant_id matching each frame.
REQ-032 Late arrival: req 2 valid mid-frame of req 0 -> req_ready[2] stays 0 until the IDLE cycle, then req 2 is granted.
REQ-033 Reset mid-frame: rst_n low in the 2nd SHIFT cycle -> sout, sout_valid and busy go 0 at once; after release with req 1,3 valid, req 0 is not asserted, so req 1 is granted first.
REQ-034 Parity on: data 4'b0111 -> sout 0,1,1,1 then parity 1; frame is 5 valid cycles.
REQ-035 Withdrawn request: req 3 valid for one cycle while busy, then low -> no ready[3], no frame for 3.
